// File: rtl/stopwatch_timer_pkg.sv
// Shared types and constants for the mm:ss stopwatch/timer.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package stopwatch_timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_hi;
    bcd_t min_lo;
    bcd_t sec_hi;
    bcd_t sec_lo;
  } mmss_t;

  localparam int SEC_MAX = 59;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [7:0] to_bcd(
    input logic [6:0] v
  );
    bcd_t t;
    bcd_t o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// One BCD digit to a seven-segment pattern.
// Non-decimal codes blank the digit.
module bcd_to_seven_seg
  import stopwatch_timer_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  bcd_t       digit,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = 7'h00;
    unique case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = 7'h00;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~pat : pat;

endmodule

// File: rtl/stopwatch_timer.sv
// mm:ss stopwatch / countdown timer with preset load,
// done flag, wrap pulse and lap freeze of the display.
module stopwatch_timer
  import stopwatch_timer_pkg::*;
#(
  parameter int TICK_DIV       = 6000,
  parameter int MIN_MAX        = 59,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       down,
  input  logic       load,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  input  logic       lap,
  output logic       done,
  output logic       wrap,
  output logic [6:0] seg_sec_lo,
  output logic [6:0] seg_sec_hi,
  output logic [6:0] seg_min_lo,
  output logic [6:0] seg_min_hi
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam bcd_t MAX_HI = 4'(MIN_MAX / 10);
  localparam bcd_t MAX_LO = 4'(MIN_MAX % 10);

  logic [PW-1:0] presc;
  mmss_t cnt, cnt_nx, disp;
  mmss_t ld_val, up_val, dn_val;
  logic frozen, lap_q;
  logic tick, lap_edge;
  logic at_max, at_zero, at_one;
  logic [6:0] ld_min;
  logic [5:0] ld_sec;

  assign tick     = run && (presc == PS_LAST);
  assign lap_edge = lap && !lap_q;
  assign at_max   = cnt == {MAX_HI, MAX_LO, 4'd5, 4'd9};
  assign at_zero  = cnt == 16'h0000;
  assign at_one   = cnt == 16'h0001;

  assign ld_min = (preset_min > 7'(MIN_MAX))
                ? 7'(MIN_MAX) : preset_min;
  assign ld_sec = (preset_sec > 6'(SEC_MAX))
                ? 6'(SEC_MAX) : preset_sec;

  always_comb begin
    ld_val = '0;
    {ld_val.min_hi, ld_val.min_lo} = to_bcd(ld_min);
    {ld_val.sec_hi, ld_val.sec_lo} = to_bcd({1'b0, ld_sec});
  end

  always_comb begin
    up_val = cnt;
    if (cnt.sec_lo != 4'd9) begin
      up_val.sec_lo = cnt.sec_lo + 4'd1;
    end else begin
      up_val.sec_lo = 4'd0;
      if (cnt.sec_hi != 4'd5) begin
        up_val.sec_hi = cnt.sec_hi + 4'd1;
      end else begin
        up_val.sec_hi = 4'd0;
        if (at_max) begin
          up_val.min_hi = 4'd0;
          up_val.min_lo = 4'd0;
        end else if (cnt.min_lo != 4'd9) begin
          up_val.min_lo = cnt.min_lo + 4'd1;
        end else begin
          up_val.min_lo = 4'd0;
          up_val.min_hi = cnt.min_hi + 4'd1;
        end
      end
    end
  end

  // 00:00 is a floor when counting down; minutes are nonzero
  // whenever a minute borrow is needed.
  always_comb begin
    dn_val = cnt;
    if (!at_zero) begin
      if (cnt.sec_lo != 4'd0) begin
        dn_val.sec_lo = cnt.sec_lo - 4'd1;
      end else begin
        dn_val.sec_lo = 4'd9;
        if (cnt.sec_hi != 4'd0) begin
          dn_val.sec_hi = cnt.sec_hi - 4'd1;
        end else begin
          dn_val.sec_hi = 4'd5;
          if (cnt.min_lo != 4'd0) begin
            dn_val.min_lo = cnt.min_lo - 4'd1;
          end else begin
            dn_val.min_lo = 4'd9;
            dn_val.min_hi = cnt.min_hi - 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (load)       cnt_nx = ld_val;
    else if (tick)  cnt_nx = down ? dn_val : up_val;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc  <= '0;
      cnt    <= '0;
      disp   <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      frozen <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      lap_q <= lap;
      cnt   <= cnt_nx;
      wrap  <= !load && tick && !down && at_max;
      if (load)
        presc <= '0;
      else if (run)
        presc <= tick ? '0 : presc + 1'b1;
      if (load || (tick && !down))
        done <= 1'b0;
      else if (tick && down && at_one)
        done <= 1'b1;
      if (lap_edge)
        frozen <= !frozen;
      if (lap_edge && !frozen)
        disp <= cnt_nx;
      else if (!frozen || lap_edge)
        disp <= cnt;
    end
  end

  bcd_to_seven_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sl (
    .digit(disp.sec_lo), .seg(seg_sec_lo)
  );
  bcd_to_seven_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sh (
    .digit(disp.sec_hi), .seg(seg_sec_hi)
  );
  bcd_to_seven_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_ml (
    .digit(disp.min_lo), .seg(seg_min_lo)
  );
  bcd_to_seven_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_mh (
    .digit(disp.min_hi), .seg(seg_min_hi)
  );

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer: three instances
// (MIN_MAX 59, MIN_MAX 2, active-low segments) on shared inputs.
module tb_stopwatch_timer;

  logic       clk, clr, run, down, load, lap;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;

  logic [6:0] sl[3], sh[3], ml[3], mh[3];
  logic       dn[3], wr[3];

  int   pass_cnt = 0;
  int   total    = 0;

  stopwatch_timer #(.TICK_DIV(4), .MIN_MAX(59), .SEG_ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .clr(clr), .run(run), .down(down), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec), .lap(lap),
    .done(dn[0]), .wrap(wr[0]),
    .seg_sec_lo(sl[0]), .seg_sec_hi(sh[0]),
    .seg_min_lo(ml[0]), .seg_min_hi(mh[0])
  );

  stopwatch_timer #(.TICK_DIV(4), .MIN_MAX(2), .SEG_ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .clr(clr), .run(run), .down(down), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec), .lap(lap),
    .done(dn[1]), .wrap(wr[1]),
    .seg_sec_lo(sl[1]), .seg_sec_hi(sh[1]),
    .seg_min_lo(ml[1]), .seg_min_hi(mh[1])
  );

  stopwatch_timer #(.TICK_DIV(4), .MIN_MAX(59), .SEG_ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .clr(clr), .run(run), .down(down), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec), .lap(lap),
    .done(dn[2]), .wrap(wr[2]),
    .seg_sec_lo(sl[2]), .seg_sec_hi(sh[2]),
    .seg_min_lo(ml[2]), .seg_min_hi(mh[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] s7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] segs(input int mm, input int ss,
                                       input bit inv);
    logic [27:0] r;
    r = {s7(mm / 10), s7(mm % 10), s7(ss / 10), s7(ss % 10)};
    return inv ? ~r : r;
  endfunction

  task automatic expect_t(input string n, input int d, input int mm,
                          input int ss, input logic dv, input logic wv);
    logic [27:0] es, as;
    bit          ok;
    es = segs(mm, ss, d == 2);
    as = {mh[d], ml[d], sh[d], sl[d]};
    ok = 1'b1;
    if (as !== es) begin
      ok = 1'b0;
      $display("FAIL %s: seg=%h expected %h", n, as, es);
    end
    if (dn[d] !== dv) begin
      ok = 1'b0;
      $display("FAIL %s: done=%b expected %b", n, dn[d], dv);
    end
    if (wr[d] !== wv) begin
      ok = 1'b0;
      $display("FAIL %s: wrap=%b expected %b", n, wr[d], wv);
    end
    total++;
    if (ok) pass_cnt++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clr = 1'b0; run = 1'b0; down = 1'b0; load = 1'b0; lap = 1'b0;
    preset_min = '0; preset_sec = '0;
    cyc(2);
    expect_t("reset_u0", 0, 0, 0, 1'b0, 1'b0);
    expect_t("reset_u1", 1, 0, 0, 1'b0, 1'b0);
    expect_t("reset_lowseg", 2, 0, 0, 1'b0, 1'b0);
    clr = 1'b1;
    run = 1'b1;

    cyc(240);
    expect_t("count_00_59", 0, 0, 59, 1'b0, 1'b0);
    cyc(1);
    expect_t("count_01_00", 0, 1, 0, 1'b0, 1'b0);
    expect_t("lowseg_01_00", 2, 1, 0, 1'b0, 1'b0);

    run = 1'b0;
    cyc(100);
    expect_t("pause_hold", 0, 1, 0, 1'b0, 1'b0);
    run = 1'b1;
    cyc(3);
    expect_t("resume_presc", 0, 1, 0, 1'b0, 1'b0);
    cyc(1);
    expect_t("resume_tick", 0, 1, 1, 1'b0, 1'b0);

    load = 1'b1; preset_min = 7'd2; preset_sec = 6'd59;
    cyc(1);
    load = 1'b0;
    cyc(3);
    expect_t("wrap_pre", 1, 2, 59, 1'b0, 1'b0);
    cyc(1);
    expect_t("wrap_pulse", 1, 2, 59, 1'b0, 1'b1);
    cyc(1);
    expect_t("wrap_after", 1, 0, 0, 1'b0, 1'b0);
    expect_t("nowrap_u0", 0, 3, 0, 1'b0, 1'b0);

    cyc(2);
    load = 1'b1; preset_min = 7'd0; preset_sec = 6'd2; down = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    expect_t("load_on_tick", 0, 0, 2, 1'b0, 1'b0);
    cyc(4);
    expect_t("down_00_01", 0, 0, 1, 1'b0, 1'b0);
    cyc(2);
    expect_t("done_pre", 0, 0, 1, 1'b0, 1'b0);
    cyc(1);
    expect_t("done_set", 0, 0, 1, 1'b1, 1'b0);
    cyc(1);
    expect_t("down_00_00", 0, 0, 0, 1'b1, 1'b0);
    cyc(40);
    expect_t("no_underflow", 0, 0, 0, 1'b1, 1'b0);
    down = 1'b0;
    cyc(3);
    expect_t("up_clears_done", 0, 0, 0, 1'b0, 1'b0);
    cyc(1);
    expect_t("up_from_zero", 0, 0, 1, 1'b0, 1'b0);

    load = 1'b1; preset_min = 7'd127; preset_sec = 6'd63;
    cyc(1);
    load = 1'b0;
    cyc(1);
    expect_t("clamp_59", 0, 59, 59, 1'b0, 1'b0);
    expect_t("clamp_2", 1, 2, 59, 1'b0, 1'b0);

    load = 1'b1; preset_min = 7'd0; preset_sec = 6'd10;
    cyc(1);
    load = 1'b0;
    cyc(4);
    expect_t("presc_restart", 0, 0, 10, 1'b0, 1'b0);
    cyc(1);
    expect_t("presc_tick", 0, 0, 11, 1'b0, 1'b0);

    load = 1'b1; preset_min = 7'd0; preset_sec = 6'd5;
    cyc(1);
    load = 1'b0; lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    cyc(16);
    expect_t("lap_frozen", 0, 0, 5, 1'b0, 1'b0);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    expect_t("lap_release", 0, 0, 9, 1'b0, 1'b0);

    #1 clr = 1'b0;
    #1;
    expect_t("async_clr", 0, 0, 0, 1'b0, 1'b0);
    expect_t("async_clr_low", 2, 0, 0, 1'b0, 1'b0);
    total++;
    if ((dn[0] | dn[1] | dn[2]) === 1'b0)
      pass_cnt++;
    else
      $display("FAIL async_clr_done: done=%b%b%b", dn[0], dn[1], dn[2]);
    #3;
    total++;
    if (pass_cnt == total - 1)
      pass_cnt++;
    else
      $display("FAIL summary: %0d of %0d earlier checks passed",
               pass_cnt, total - 1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
